dual_buffer_dac: RTL and testbench
==================================

// Module: dual_buffer_dac
// PURPOSE
//   Ping-pong waveform playback buffer, the DAC-side counterpart of the ADC capture buffer.
//   The MCU fills the back buffer over the FSMC-style bus, sets the length and commits.
//   The block plays the front buffer cyclically to the DAC, paced by dac_clk.
//   Commit swaps buffers only at a period boundary, so the output never glitches mid-waveform.
// PARAMETERS
//   DATA_WIDTH  16    bus address/data width
//   BUF_SIZE    1024  samples per buffer (power of 2)
//   DAC_WIDTH   12    DAC sample width; bus data bits [DAC_WIDTH-1:0] are used
// PORTS
//   clk       in   1           system clock, single clock domain
//   rst       in   1           synchronous, active-high reset
//   dac_clk   in   1           DAC sample clock; asynchronous, sampled in clk domain
//   dac_data  out  DAC_WIDTH   sample to DAC
//   playing   out  1           1 while the playback FSM is in PLAY
//   en        in   1           bus transaction enable (chip select)
//   state     in   1           0: MCU writes to block; 1: block drives wr_data (MCU read)
//   rd_data   in   DATA_WIDTH  address at en rising edge, then write data
//   wr_data   out  DATA_WIDTH  read-back data to MCU
// BEHAVIOUR
//   Reset (rst=1 at a clk edge): dac_data=0, playing=0, wr_data=0.
//     Also run=0, swap_pending=0, front_sel=0, front_len=0, back_len=0, rd_ptr=0, bus FSM in IDLE.
//     Buffer RAM contents are not cleared.
//   Register map (addr latched at en rising edge):
//     0..BUF_SIZE-1  W: back[addr]<=rd_data[DAC_WIDTH-1:0]; R: {0,back[addr]}
//     16'h4000 CTRL  W: bit0=run, bit1=commit (a write with bit1=1 requests a swap); R: {15'b0,run}
//     16'h4001 LEN   W: back_len<=min(rd_data,BUF_SIZE); R: back_len
//     16'h4002 STAT  R: {13'b0, swap_pending, (front_len!=0), playing}
//     other          W: ignored; R: 16'hFFFF
//   Bus FSM: IDLE -> JUDGE -> READ or WRITE -> IDLE. en is edge-detected with a registered copy.
//     IDLE: on en rising edge, latch addr<=rd_data and go to JUDGE. wr_data=0 while in IDLE.
//     JUDGE (1 cycle): state=1 -> WRITE; state=0 -> READ.
//     READ: on en falling edge, commit rd_data to addr, then IDLE.
//     WRITE: wr_data is updated every cycle from addr; en=0 -> IDLE.
//   dac_clk is passed through a 2-flop synchronizer. tick = (sync==2'b01).
//     dac_data updates on the clk edge where tick=1, i.e. 3 clk cycles after the dac_clk pin rises.
//     dac_clk high and low phases must each be at least 3 clk cycles.
//   Playback FSM:
//     STOP: when run=1 and front_len!=0, go to PLAY with rd_ptr=0. dac_data holds its value.
//     PLAY: when run=0, go to STOP (dac_data holds its last value, rd_ptr=0).
//       Otherwise, on tick: dac_data<=front[rd_ptr].
//       If rd_ptr==front_len-1 (wrap): rd_ptr<=0; if swap_pending then toggle front_sel,
//       front_len<=back_len, swap_pending<=0. Otherwise rd_ptr<=rd_ptr+1.
//   Commit handling:
//     In STOP: the swap happens on the next clk.
//     In PLAY: swap_pending<=1, and the swap waits for the next wrap.
//     A commit while swap_pending=1 has no extra effect.
//     A commit landing on the same cycle as a wrap sees the old swap_pending=0 and is served at the following wrap.
//   LEN=0 committed: front_len=0 takes effect at the wrap; the FSM then goes to STOP (playing=0).
//   Sample writes always target the back buffer, including while swap_pending=1.
//   RAM: one write port (bus) and two read ports (playback front, bus back); infer as dual buffers.
//   rst mid-transfer: bus and playback FSMs return to IDLE/STOP immediately; a pending swap is discarded.
// TESTING
//   1. Write back[0..3]=100,200,300,400, LEN=4, CTRL=3 while STOP.
//      -> swap; dac_data sequence 100,200,300,400,100... one value per dac_clk; playing=1.
//   2. While playing, load back[0..1]=7,9, LEN=2, commit mid-period.
//      -> STAT bit2=1; after the current 400, the output is 7,9,7,9; bit2 clears at the swap.
//   3. Commit strobe on the same clk as a wrap tick -> swap occurs at the next wrap, not this one.
//   4. MCU read of STAT, of back[1], and of addr 16'h5000 -> expected bits, 9 (back[1] value), 16'hFFFF.
//      wr_data=0 once en drops.
//   5. LEN write of 16'h0800 reads back as 1024. A committed LEN=0 -> playing=0, dac_data holds its last value.
//   6. Assert rst mid-PLAY and mid-bus-READ -> all outputs 0 the next cycle.
//      The interrupted write is not committed; STAT reads 0.

Source files
------------

// File: rtl/dual_buffer_dac_if.sv
// MCU-side FSMC-style bus for the waveform playback buffer.
// The master (MCU) drives en/state/rd_data; the slave (this block) drives wr_data.
interface dual_buffer_dac_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  en;
  logic                  state;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [DATA_WIDTH-1:0] wr_data;

  modport master (output en, output state, output rd_data, input wr_data);
  modport slave  (input en, input state, input rd_data, output wr_data);
endinterface

// File: rtl/dual_buffer_dac.sv
// Ping-pong waveform playback buffer. The MCU fills the back buffer, sets its
// length and commits; the front buffer is played cyclically to the DAC at the
// dac_clk rate. Buffers swap only at a period wrap so the output never glitches.
module dual_buffer_dac #(
  parameter int DATA_WIDTH = 16,
  parameter int BUF_SIZE   = 1024,
  parameter int DAC_WIDTH  = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 dac_clk,
  output logic [DAC_WIDTH-1:0] dac_data,
  output logic                 playing,
  dual_buffer_dac_if.slave     bus
);
  localparam int AW = $clog2(BUF_SIZE);
  localparam int LW = AW + 1;
  localparam logic [DATA_WIDTH-1:0] CTRL_ADDR = DATA_WIDTH'(16'h4000);
  localparam logic [DATA_WIDTH-1:0] LEN_ADDR  = DATA_WIDTH'(16'h4001);
  localparam logic [DATA_WIDTH-1:0] STAT_ADDR = DATA_WIDTH'(16'h4002);
  localparam logic [LW-1:0]         LEN_MAX   = LW'(BUF_SIZE);

  typedef enum logic [1:0] {IDLE, JUDGE, READ, WRITE} bus_state_t;
  typedef enum logic {STOP, PLAY} play_state_t;

  bus_state_t            bus_st;
  play_state_t           play_st;
  logic                  en_reg;
  logic [DATA_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wr_data_reg;
  logic [DATA_WIDTH-1:0] rd_mux;
  logic                  run;
  logic [LW-1:0]         back_len;
  logic [LW-1:0]         front_len;
  logic                  swap_pending;
  logic                  front_sel;
  logic [AW-1:0]         rd_ptr;
  logic                  dac_meta;
  logic [1:0]            dac_sync;
  logic [DAC_WIDTH-1:0]  front_q;
  logic [DAC_WIDTH-1:0]  back_q;

  logic          en_rise;
  logic          en_fall;
  logic          in_buf;
  logic          bus_we;
  logic          commit_req;
  logic          tick;
  logic          wrap;
  logic [AW-1:0] bus_idx;

  assign en_rise    = bus.en & ~en_reg;
  assign en_fall    = ~bus.en & en_reg;
  assign bus_idx    = addr[AW-1:0];
  assign in_buf     = (addr[DATA_WIDTH-1:AW] == '0);
  assign bus_we     = (bus_st == READ) && en_fall && in_buf;
  assign commit_req = (bus_st == READ) && en_fall && (addr == CTRL_ADDR) && bus.rd_data[1];
  assign tick       = (dac_sync == 2'b01);
  assign wrap       = ({1'b0, rd_ptr} == front_len - LW'(1));
  assign bus.wr_data = wr_data_reg;

  // Two physical buffers; the one not selected as front is the back buffer.
  // Each buffer has one write port (bus, back only) and one registered read
  // port whose address follows its current role: playback pointer or bus address.
  for (genvar gi = 0; gi < 2; gi++) begin : g_buf
    logic [DAC_WIDTH-1:0] mem [BUF_SIZE];
    logic [DAC_WIDTH-1:0] q;
    logic                 is_front;
    logic [AW-1:0]        raddr;

    assign is_front = (front_sel == 1'(gi));
    assign raddr    = is_front ? rd_ptr : bus_idx;

    // Back-buffer sample writes and registered read
    always_ff @(posedge clk) begin
      if (bus_we && !is_front) mem[bus_idx] <= bus.rd_data[DAC_WIDTH-1:0];
      q <= mem[raddr];
    end
  end

  assign front_q = front_sel ? g_buf[1].q : g_buf[0].q;
  assign back_q  = front_sel ? g_buf[0].q : g_buf[1].q;

  // Read-back mux for the MCU read phase
  always_comb begin
    rd_mux = '1;
    if (in_buf)                  rd_mux = DATA_WIDTH'(back_q);
    else if (addr == CTRL_ADDR)  rd_mux = DATA_WIDTH'(run);
    else if (addr == LEN_ADDR)   rd_mux = DATA_WIDTH'(back_len);
    else if (addr == STAT_ADDR)  rd_mux = DATA_WIDTH'({swap_pending, front_len != '0, playing});
  end

  // Synchronize dac_clk; the extra history bit gives the rising-edge tick
  always_ff @(posedge clk) begin
    if (rst) begin
      dac_meta <= 1'b0;
      dac_sync <= 2'b00;
    end else begin
      dac_meta <= dac_clk;
      dac_sync <= {dac_sync[0], dac_meta};
    end
  end

  // Bus FSM: latch address on en rise, then either accept data on en fall or drive read-back
  always_ff @(posedge clk) begin
    if (rst) begin
      bus_st      <= IDLE;
      en_reg      <= 1'b0;
      addr        <= '0;
      wr_data_reg <= '0;
      run         <= 1'b0;
      back_len    <= '0;
    end else begin
      en_reg <= bus.en;
      case (bus_st)
        IDLE: begin
          wr_data_reg <= '0;
          if (en_rise) begin
            addr   <= bus.rd_data;
            bus_st <= JUDGE;
          end
        end
        JUDGE: bus_st <= bus.state ? WRITE : READ;
        READ: begin
          if (en_fall) begin
            if (addr == CTRL_ADDR) begin
              run <= bus.rd_data[0];
            end else if (addr == LEN_ADDR) begin
              if (bus.rd_data > DATA_WIDTH'(BUF_SIZE)) back_len <= LEN_MAX;
              else                                     back_len <= bus.rd_data[LW-1:0];
            end
            bus_st <= IDLE;
          end
        end
        WRITE: begin
          if (!bus.en) begin
            wr_data_reg <= '0;
            bus_st      <= IDLE;
          end else begin
            wr_data_reg <= rd_mux;
          end
        end
        default: bus_st <= IDLE;
      endcase
    end
  end

  // Playback FSM: cyclic front-buffer playout, swap deferred to the period wrap
  always_ff @(posedge clk) begin
    if (rst) begin
      play_st      <= STOP;
      playing      <= 1'b0;
      dac_data     <= '0;
      rd_ptr       <= '0;
      front_sel    <= 1'b0;
      front_len    <= '0;
      swap_pending <= 1'b0;
    end else begin
      // A commit only raises the request; a swap in the same cycle clears it below
      if (commit_req) swap_pending <= 1'b1;
      case (play_st)
        STOP: begin
          rd_ptr <= '0;
          if (swap_pending) begin
            front_sel    <= ~front_sel;
            front_len    <= back_len;
            swap_pending <= 1'b0;
          end else if (run && front_len != '0) begin
            play_st <= PLAY;
            playing <= 1'b1;
          end
        end
        PLAY: begin
          if (!run || front_len == '0) begin
            play_st <= STOP;
            playing <= 1'b0;
            rd_ptr  <= '0;
          end else if (tick) begin
            dac_data <= front_q;
            if (wrap) begin
              rd_ptr <= '0;
              if (swap_pending) begin
                front_sel    <= ~front_sel;
                front_len    <= back_len;
                swap_pending <= 1'b0;
              end
            end else begin
              rd_ptr <= rd_ptr + 1'b1;
            end
          end
        end
        default: begin
          play_st <= STOP;
          playing <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_dual_buffer_dac.sv
// Self-checking bench for dual_buffer_dac: directed scenarios plus a random
// phase, all checked against a sample-level reference model of the buffer.
module tb_dual_buffer_dac;
  localparam int DW = 16;
  localparam int BS = 1024;
  localparam int XW = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic dac_clk = 1'b0;
  logic [XW-1:0] dac_data;
  logic playing;

  dual_buffer_dac_if #(.DATA_WIDTH(DW)) bus();

  dual_buffer_dac #(.DATA_WIDTH(DW), .BUF_SIZE(BS), .DAC_WIDTH(XW)) dut (
    .clk(clk), .rst(rst), .dac_clk(dac_clk),
    .dac_data(dac_data), .playing(playing), .bus(bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: the two buffers as "front" and "back" sample arrays
  int m_front[BS];
  int m_back[BS];
  int m_flen, m_blen, m_ptr, m_dac;
  bit m_run, m_pend, m_play;

  task automatic check_equal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic void m_reset();
    m_flen = 0; m_blen = 0; m_ptr = 0; m_dac = 0;
    m_run = 0; m_pend = 0; m_play = 0;
  endfunction

  function automatic void m_swap();
    int tmp[BS];
    tmp = m_front; m_front = m_back; m_back = tmp;
    m_flen = m_blen;
  endfunction

  function automatic void m_settle();
    if (m_play && !m_run) begin m_play = 0; m_ptr = 0; end
    if (!m_play && m_pend) begin m_swap(); m_pend = 0; end
    if (!m_play && m_run && m_flen != 0) begin m_play = 1; m_ptr = 0; end
  endfunction

  function automatic void m_tick();
    if (m_play) begin
      m_dac = m_front[m_ptr];
      if (m_ptr == m_flen - 1) begin
        m_ptr = 0;
        if (m_pend) begin m_swap(); m_pend = 0; end
        if (m_flen == 0) m_play = 0;
      end else begin
        m_ptr++;
      end
    end
    m_settle();
  endfunction

  function automatic void m_bus_write(input int a, input int d);
    if (a < BS) m_back[a] = d & 'hFFF;
    else if (a == 'h4000) begin
      m_run = d[0];
      if (d[1]) m_pend = 1;
    end else if (a == 'h4001) m_blen = (d > BS) ? BS : d;
    m_settle();
  endfunction

  function automatic int m_read(input int a);
    if (a < BS)       return m_back[a];
    if (a == 'h4000)  return int'(m_run);
    if (a == 'h4001)  return m_blen;
    if (a == 'h4002)  return (int'(m_pend) << 2) | (int'(m_flen != 0) << 1) | int'(m_play);
    return 'hFFFF;
  endfunction

  task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
    @(negedge clk); bus.rd_data = a; bus.state = 1'b0; bus.en = 1'b1;
    repeat (3) @(negedge clk); bus.rd_data = d;
    @(negedge clk); bus.en = 1'b0;
    repeat (2) @(negedge clk);
    m_bus_write(int'(a), int'(d));
    $display("[TB] bus write addr=%h data=%h", a, d);
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [15:0] v);
    @(negedge clk); bus.rd_data = a; bus.state = 1'b1; bus.en = 1'b1;
    repeat (4) @(negedge clk); v = bus.wr_data;
    bus.en = 1'b0;
    @(negedge clk);
    check_equal("rd_idle_zero", 32'(bus.wr_data), 32'h0);
    $display("[TB] bus read  addr=%h data=%h", a, v);
  endtask

  task automatic bus_read_check(input string tag, input logic [15:0] a);
    logic [15:0] v;
    int exp;
    exp = m_read(int'(a));
    bus_read(a, v);
    check_equal(tag, 32'(v), 32'(exp));
  endtask

  task automatic dac_period(input string tag);
    @(negedge clk); dac_clk = 1'b1;
    repeat (4) @(negedge clk); dac_clk = 1'b0;
    repeat (4) @(negedge clk);
    m_tick();
    check_equal({tag, "_dac"}, 32'(dac_data), 32'(m_dac));
    check_equal({tag, "_play"}, 32'(playing), 32'(m_play));
    $display("[TB] dac tick dac_data=%0d playing=%0b", dac_data, playing);
  endtask

  // dac_period plus an independent constant expectation for directed steps
  task automatic dac_expect(input string tag, input int exp);
    dac_period(tag);
    check_equal({tag, "_const"}, 32'(dac_data), 32'(exp));
  endtask

  // CTRL write whose en falling edge lands on the same clk edge as the dac tick
  task automatic ctrl_on_tick(input logic [15:0] d);
    @(negedge clk); bus.rd_data = 16'h4000; bus.state = 1'b0; bus.en = 1'b1;
    repeat (3) @(negedge clk); bus.rd_data = d;
    @(negedge clk); dac_clk = 1'b1;
    @(negedge clk);
    @(negedge clk); bus.en = 1'b0;
    repeat (2) @(negedge clk); dac_clk = 1'b0;
    repeat (4) @(negedge clk);
    m_tick();
    m_bus_write(16'h4000, int'(d));
    check_equal("t3_wrap_dac", 32'(dac_data), 32'(m_dac));
    check_equal("t3_wrap_play", 32'(playing), 32'(m_play));
    $display("[TB] ctrl-on-tick data=%h dac_data=%0d", d, dac_data);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] v;
    logic [15:0] ra_tab[6];
    int t1[6];
    ra_tab = '{16'h0000, 16'h0003, 16'h4000, 16'h4001, 16'h4002, 16'h7777};
    t1 = '{100, 200, 300, 400, 100, 200};
    bus.en = 1'b0; bus.state = 1'b0; bus.rd_data = '0;
    m_reset();
    foreach (m_front[i]) begin m_front[i] = 0; m_back[i] = 0; end

    // Reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_equal("rst_dac", 32'(dac_data), 32'h0);
    check_equal("rst_play", 32'(playing), 32'h0);
    check_equal("rst_wr_data", 32'(bus.wr_data), 32'h0);
    bus_read_check("rst_stat", 16'h4002);

    // Make both physical buffers hold known samples at 0..7
    for (int i = 0; i < 8; i++) bus_write(16'(i), 16'($urandom));
    bus_write(16'h4000, 16'h0002);
    for (int i = 0; i < 8; i++) bus_write(16'(i), 16'($urandom));

    // 1: load and start from STOP
    bus_write(16'h0000, 16'd100); bus_write(16'h0001, 16'd200);
    bus_write(16'h0002, 16'd300); bus_write(16'h0003, 16'd400);
    bus_write(16'h4001, 16'd4);
    bus_write(16'h4000, 16'h0003);
    for (int i = 0; i < 6; i++) dac_expect("t1", t1[i]);
    check_equal("t1_playing", 32'(playing), 32'h1);

    // 2: commit mid-period, swap deferred to the wrap
    bus_write(16'h0000, 16'd7); bus_write(16'h0001, 16'd9);
    bus_write(16'h4001, 16'd2);
    bus_write(16'h4000, 16'h0003);
    bus_read(16'h4002, v);
    check_equal("t2_stat_pending", 32'(v), 32'h7);
    dac_expect("t2", 300); dac_expect("t2", 400);
    dac_expect("t2", 7);   dac_expect("t2", 9);
    dac_expect("t2", 7);   dac_expect("t2", 9);
    bus_read(16'h4002, v);
    check_equal("t2_stat_cleared", 32'(v), 32'h3);

    // 3: commit on the same clk as a wrap tick
    bus_write(16'h0000, 16'd55); bus_write(16'h0001, 16'd66);
    bus_write(16'h4001, 16'd3);
    dac_expect("t3", 7);
    ctrl_on_tick(16'h0003);
    check_equal("t3_wrap_const", 32'(dac_data), 32'd9);
    bus_read(16'h4002, v);
    check_equal("t3_stat_pending", 32'(v), 32'h7);
    dac_expect("t3", 7);  dac_expect("t3", 9);
    dac_expect("t3", 55); dac_expect("t3", 66);

    // 4: MCU reads
    bus_read_check("t4_stat", 16'h4002);
    bus_read(16'h0001, v);
    check_equal("t4_back1", 32'(v), 32'd9);
    bus_read(16'h5000, v);
    check_equal("t4_unmapped", 32'(v), 32'hFFFF);

    // 5: LEN clamp, then commit LEN=0 and stop at the wrap
    bus_write(16'h4001, 16'h0800);
    bus_read(16'h4001, v);
    check_equal("t5_len_clamp", 32'(v), 32'd1024);
    bus_write(16'h4001, 16'h0000);
    bus_write(16'h4000, 16'h0003);
    dac_expect("t5", 300);
    check_equal("t5_stopped", 32'(playing), 32'h0);
    dac_expect("t5_hold", 300);

    // Random phase
    for (int it = 0; it < 60; it++) begin
      case ($urandom_range(0, 5))
        0: bus_write(16'($urandom_range(0, 7)), 16'($urandom));
        1: bus_write(16'h4001, 16'($urandom_range(0, 8)));
        2: bus_write(16'h4000, ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 3)) : 16'h0003);
        3: bus_read_check("rnd_read", ra_tab[$urandom_range(0, 5)]);
        default: dac_period("rnd");
      endcase
    end

    // 6: reset in the middle of playback and of an MCU write
    bus_write(16'h4001, 16'd3);
    bus_write(16'h4000, 16'h0003);
    dac_period("t6_pre");
    dac_period("t6_pre");
    @(negedge clk); bus.rd_data = 16'h0000; bus.state = 1'b0; bus.en = 1'b1;
    repeat (3) @(negedge clk); bus.rd_data = 16'h0ABC;
    rst = 1'b1;
    @(negedge clk);
    check_equal("t6_rst_dac", 32'(dac_data), 32'h0);
    check_equal("t6_rst_play", 32'(playing), 32'h0);
    check_equal("t6_rst_wr_data", 32'(bus.wr_data), 32'h0);
    bus.en = 1'b0;
    @(negedge clk); rst = 1'b0;
    m_reset();
    repeat (2) @(negedge clk);
    bus_read(16'h4002, v);
    check_equal("t6_stat_zero", 32'(v), 32'h0);
    bus_read(16'h4001, v);
    check_equal("t6_len_zero", 32'(v), 32'h0);
    dac_period("t6_post");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
